// File: rtl/debounce_bank.sv
// ---------------------------------------------------------------------------
// debounce_bank
//   Synchronises and debounces CHANNELS active-low push-buttons, classifies
//   each accepted press as short, long or hold, and emits one-cycle event
//   pulses per channel. A single shared prescaler sets the tick granularity.
//
// Parameters
//   CHANNELS     number of independent buttons
//   TICK_DIV     i_clk cycles per timing tick (>= 2)
//   DEB_TICKS    ticks a press must stay stable before it is accepted
//   LONG_TICKS   held ticks at/above which a release is classified long
//   HOLD_TICKS   held ticks at which the hold event fires
//   REPEAT_TICKS auto-repeat period in ticks while held (repeat build only)
//
// Ports
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset
//   i_sw         raw buttons, asynchronous, 0 = pressed
//   o_pressed    debounced level, 1 = accepted press in progress
//   o_short      1-cycle pulse on release of a short press
//   o_long       1-cycle pulse on release of a long press
//   o_hold       1-cycle pulse when a press reaches HOLD_TICKS
//   o_repeat     1-cycle auto-repeat pulse while held
//
// Build option
//   DEBOUNCE_BANK_REPEAT_EN  define to build the auto-repeat counter;
//                            when undefined o_repeat is tied to 0.
// ---------------------------------------------------------------------------
module debounce_bank #(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned TICK_DIV     = 1000,
  parameter int unsigned DEB_TICKS    = 20,
  parameter int unsigned LONG_TICKS   = 500,
  parameter int unsigned HOLD_TICKS   = 2000,
  parameter int unsigned REPEAT_TICKS = 200
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [CHANNELS-1:0] i_sw,
  output logic [CHANNELS-1:0] o_pressed,
  output logic [CHANNELS-1:0] o_short,
  output logic [CHANNELS-1:0] o_long,
  output logic [CHANNELS-1:0] o_hold,
  output logic [CHANNELS-1:0] o_repeat
);

  localparam int unsigned DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_W  = $clog2(HOLD_TICKS + 1);
  localparam int unsigned SYNC_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BOUNCE  = 2'd1,
    ST_PRESSED = 2'd2,
    ST_HELD    = 2'd3
  } state_e;

  // Reject parameter sets that cannot produce a working classifier.
  if (TICK_DIV < 2 || DEB_TICKS == 0 || DEB_TICKS >= LONG_TICKS ||
      LONG_TICKS >= HOLD_TICKS || REPEAT_TICKS == 0) begin : g_cfg_err
    $error("debounce_bank: illegal timing parameters");
  end

  // -------------------------------------------------------------------------
  // Shared prescaler: free-running 0..TICK_DIV-1, tick on the wrap cycle.
  // -------------------------------------------------------------------------
  logic [DIV_W-1:0] div_q;
  logic             tick_c;

  assign tick_c = (div_q == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin : prescaler_reg
    if (!i_rst_n) begin
      div_q <= '0;
    end else if (tick_c) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Per-channel synchroniser, press classifier and event registers.
  // -------------------------------------------------------------------------
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [SYNC_W-1:0] sync_q;
    logic              s_c;
    state_e            state_q;
    state_e            state_nx;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_nx;
    logic [CNT_W-1:0]  cnt_inc_c;
    logic              pressed_c;
    logic              short_c;
    logic              long_c;
    logic              hold_c;
    logic              repeat_c;
    logic              pressed_q;
    logic              short_q;
    logic              long_q;
    logic              hold_q;
    logic              repeat_q;

    // Three-flop synchroniser, resets to released (all ones).
    always_ff @(posedge i_clk or negedge i_rst_n) begin : sync_reg
      if (!i_rst_n) begin
        sync_q <= '1;
      end else begin
        sync_q <= {sync_q[SYNC_W-2:0], i_sw[g]};
      end
    end

    assign s_c = sync_q[SYNC_W-1];

    // Saturating increment: the tick count never wraps past HOLD_TICKS.
    assign cnt_inc_c = (cnt_q == CNT_W'(HOLD_TICKS)) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef DEBOUNCE_BANK_REPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_TICKS + 1);

    logic [REP_W-1:0] rep_q;
    logic [REP_W-1:0] rep_nx;
    logic [REP_W-1:0] rep_inc_c;

    assign rep_inc_c = rep_q + REP_W'(1);

    // Repeat counter: held at zero outside HELD so entry always starts fresh.
    always_comb begin : rep_next
      rep_nx = rep_q;
      if (state_q != ST_HELD) begin
        rep_nx = '0;
      end else if (!s_c && tick_c) begin
        rep_nx = (rep_inc_c == REP_W'(REPEAT_TICKS)) ? '0 : rep_inc_c;
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin : rep_reg
      if (!i_rst_n) begin
        rep_q <= '0;
      end else begin
        rep_q <= rep_nx;
      end
    end
`endif

    // State register plus registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin : state_reg
      if (!i_rst_n) begin
        state_q   <= ST_IDLE;
        cnt_q     <= '0;
        pressed_q <= 1'b0;
        short_q   <= 1'b0;
        long_q    <= 1'b0;
        hold_q    <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        state_q   <= state_nx;
        cnt_q     <= cnt_nx;
        pressed_q <= pressed_c;
        short_q   <= short_c;
        long_q    <= long_c;
        hold_q    <= hold_c;
        repeat_q  <= repeat_c;
      end
    end

    // Next state and tick count. A release always takes priority over tick.
    always_comb begin : next_state
      state_nx = state_q;
      cnt_nx   = cnt_q;
      unique case (state_q)
        ST_IDLE: begin
          if (!s_c) begin
            state_nx = ST_BOUNCE;
            cnt_nx   = '0;
          end
        end
        ST_BOUNCE: begin
          if (s_c) begin
            state_nx = ST_IDLE;
          end else if (tick_c) begin
            cnt_nx = cnt_inc_c;
            if (cnt_inc_c == CNT_W'(DEB_TICKS)) begin
              state_nx = ST_PRESSED;
            end
          end
        end
        ST_PRESSED: begin
          if (s_c) begin
            state_nx = ST_IDLE;
          end else if (tick_c) begin
            cnt_nx = cnt_inc_c;
            if (cnt_inc_c == CNT_W'(HOLD_TICKS)) begin
              state_nx = ST_HELD;
            end
          end
        end
        ST_HELD: begin
          if (s_c) begin
            state_nx = ST_IDLE;
          end
        end
        default: begin
          state_nx = ST_IDLE;
        end
      endcase
    end

    // Next values of the registered outputs; classification uses the count
    // before any coincident tick, so a release on the hold tick reads long.
    always_comb begin : out_next
      pressed_c = 1'b0;
      short_c   = 1'b0;
      long_c    = 1'b0;
      hold_c    = 1'b0;
      repeat_c  = 1'b0;
      pressed_c = (state_nx == ST_PRESSED) || (state_nx == ST_HELD);
      if (state_q == ST_PRESSED) begin
        if (s_c) begin
          if (cnt_q >= CNT_W'(LONG_TICKS)) begin
            long_c = 1'b1;
          end else begin
            short_c = 1'b1;
          end
        end else if (state_nx == ST_HELD) begin
          hold_c = 1'b1;
        end
      end
`ifdef DEBOUNCE_BANK_REPEAT_EN
      if ((state_q == ST_HELD) && !s_c && tick_c &&
          (rep_inc_c == REP_W'(REPEAT_TICKS))) begin
        repeat_c = 1'b1;
      end
`endif
    end

    assign o_pressed[g] = pressed_q;
    assign o_short[g]   = short_q;
    assign o_long[g]    = long_q;
    assign o_hold[g]    = hold_q;
    assign o_repeat[g]  = repeat_q;
  end

endmodule

// File: tb/tb_debounce_bank.sv
// ---------------------------------------------------------------------------
// tb_debounce_bank
//   Self-checking bench for debounce_bank. A reference model derives every
//   output from the run length of ticks each button has been stably low,
//   and is compared against the DUT on every cycle. A vector table covers
//   the press classes, with hand sequences for reset and concurrency.
// ---------------------------------------------------------------------------
module tb_debounce_bank;

  localparam int unsigned CH   = 4;
  localparam int unsigned TD   = 4;
  localparam int unsigned DEB  = 2;
  localparam int unsigned LONG = 5;
  localparam int unsigned HOLD = 8;
  localparam int unsigned REP  = 2;
`ifdef DEBOUNCE_BANK_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [CH-1:0] i_sw;
  logic [CH-1:0] o_pressed;
  logic [CH-1:0] o_short;
  logic [CH-1:0] o_long;
  logic [CH-1:0] o_hold;
  logic [CH-1:0] o_repeat;

  always #5 i_clk = ~i_clk;

  debounce_bank #(
    .CHANNELS    (CH),
    .TICK_DIV    (TD),
    .DEB_TICKS   (DEB),
    .LONG_TICKS  (LONG),
    .HOLD_TICKS  (HOLD),
    .REPEAT_TICKS(REP)
  ) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_sw     (i_sw),
    .o_pressed(o_pressed),
    .o_short  (o_short),
    .o_long   (o_long),
    .o_hold   (o_hold),
    .o_repeat (o_repeat)
  );

  int vectors;
  int miscompares;
  int cyc;

  // Reference model state: input delay line, edge count since reset and
  // number of ticks each channel has spent continuously low (-1 = released).
  logic [2:0]    m_hist [CH];
  int            m_run  [CH];
  int            m_edges;
  logic [CH-1:0] m_pressed, m_short, m_long, m_hold, m_repeat;

  int obs_press [CH];
  int obs_short [CH];
  int obs_long  [CH];
  int obs_hold  [CH];
  int obs_rep   [CH];
  int last_rep  [CH];

  task automatic model_reset();
    m_edges   = 0;
    m_pressed = '0;
    m_short   = '0;
    m_long    = '0;
    m_hold    = '0;
    m_repeat  = '0;
    for (int c = 0; c < int'(CH); c++) begin
      m_hist[c] = 3'b111;
      m_run[c]  = -1;
    end
  endtask

  // One rising edge of the model, using the inputs that edge sampled.
  task automatic model_edge();
    bit tk;
    bit s;
    tk = (m_edges % int'(TD)) == int'(TD) - 1;
    m_edges++;
    m_short  = '0;
    m_long   = '0;
    m_hold   = '0;
    m_repeat = '0;
    for (int c = 0; c < int'(CH); c++) begin
      s         = m_hist[c][2];
      m_hist[c] = {m_hist[c][1:0], i_sw[c]};
      if (!s) begin
        if (m_run[c] < 0) begin
          m_run[c] = 0;
        end else if (tk) begin
          m_run[c]++;
          if (m_run[c] == int'(HOLD)) m_hold[c] = 1'b1;
          if (REP_EN && m_run[c] > int'(HOLD) &&
              ((m_run[c] - int'(HOLD)) % int'(REP)) == 0) m_repeat[c] = 1'b1;
        end
      end else begin
        if (m_run[c] >= int'(DEB) && m_run[c] < int'(HOLD)) begin
          if (m_run[c] >= int'(LONG)) m_long[c] = 1'b1;
          else                        m_short[c] = 1'b1;
        end
        m_run[c] = -1;
      end
      m_pressed[c] = (m_run[c] >= int'(DEB));
    end
  endtask

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  // Advance one clock; compare the DUT with the model and tally events.
  task automatic step();
    @(negedge i_clk);
    cyc++;
    if (i_rst_n) model_edge();
    vectors++;
    if ({o_pressed, o_short, o_long, o_hold, o_repeat} !=
        {m_pressed, m_short, m_long, m_hold, m_repeat}) begin
      miscompares++;
      $display("FAIL model cyc=%0d got p=%b s=%b l=%b h=%b r=%b want p=%b s=%b l=%b h=%b r=%b",
               cyc, o_pressed, o_short, o_long, o_hold, o_repeat,
               m_pressed, m_short, m_long, m_hold, m_repeat);
    end
    for (int c = 0; c < int'(CH); c++) begin
      obs_press[c] += int'(o_pressed[c]);
      obs_short[c] += int'(o_short[c]);
      obs_long[c]  += int'(o_long[c]);
      obs_hold[c]  += int'(o_hold[c]);
      obs_rep[c]   += int'(o_repeat[c]);
      if (!o_pressed[c]) last_rep[c] = -1;
      if (o_hold[c]) last_rep[c] = cyc;
      if (o_repeat[c]) begin
        if (last_rep[c] >= 0) check("repeat_gap", cyc - last_rep[c], int'(REP * TD));
        last_rep[c] = cyc;
      end
    end
  endtask

  task automatic clear_obs();
    for (int c = 0; c < int'(CH); c++) begin
      obs_press[c] = 0;
      obs_short[c] = 0;
      obs_long[c]  = 0;
      obs_hold[c]  = 0;
      obs_rep[c]   = 0;
    end
  endtask

  // Cycles from reset release until o_pressed[ch], less the 3-edge
  // synchroniser and the edge on which the FSM first sees the press.
  task automatic measure_accept(input int ch, input string name);
    int j;
    j = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (o_pressed[ch] && j == 0) j = k;
    end
    if (j == 0) begin
      check({name, "_timeout"}, 0, 1);
    end else begin
      check({name, "_min"}, int'(j - 4 >= 5), 1);
      check({name, "_max"}, int'(j - 4 <= 8), 1);
    end
  endtask

  typedef struct {
    int ch;
    int low;
    int e_press;
    int e_short;
    int e_long;
    int e_hold;
    int e_rep;
    int e_lat;
  } vec_t;

  vec_t tbl [6];
  int   rem [CH];

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    for (int c = 0; c < int'(CH); c++) last_rep[c] = -1;
    clear_obs();

    //          ch low pr sh lg hd rep              lat
    tbl[0] = '{1,  3, 0, 0, 0, 0, 0,               -1};
    tbl[1] = '{2, 16, 1, 1, 0, 0, 0,                4};
    tbl[2] = '{3, 26, 1, 0, 1, 0, 0,                4};
    tbl[3] = '{0, 60, 1, 0, 0, 1, REP_EN ? 3 : 0,  -1};
    tbl[4] = '{1, 10, 1, 1, 0, 0, 0,                4};
    tbl[5] = '{3, 34, 1, 0, 0, 1, 0,               -1};

    // Reset with button 0 already held, then release reset.
    i_rst_n = 1'b0;
    i_sw    = '1;
    i_sw[0] = 1'b0;
    model_reset();
    repeat (3) step();
    check("reset_outputs", int'({o_pressed, o_short, o_long, o_hold, o_repeat}), 0);
    i_rst_n = 1'b1;
    measure_accept(0, "reset_accept");
    i_sw[0] = 1'b1;
    repeat (20) step();

    // Table-driven single presses.
    for (int t = 0; t < 6; t++) begin
      int lat;
      clear_obs();
      i_sw[tbl[t].ch] = 1'b0;
      repeat (tbl[t].low) step();
      i_sw[tbl[t].ch] = 1'b1;
      lat = -1;
      for (int j = 1; j <= 14; j++) begin
        step();
        if (lat < 0 && (o_short[tbl[t].ch] || o_long[tbl[t].ch])) lat = j;
      end
      check($sformatf("t%0d_pressed", t), int'(obs_press[tbl[t].ch] > 0), tbl[t].e_press);
      check($sformatf("t%0d_short", t), obs_short[tbl[t].ch], tbl[t].e_short);
      check($sformatf("t%0d_long", t), obs_long[tbl[t].ch], tbl[t].e_long);
      check($sformatf("t%0d_hold", t), obs_hold[tbl[t].ch], tbl[t].e_hold);
      check($sformatf("t%0d_repeat", t), obs_rep[tbl[t].ch], tbl[t].e_rep);
      check($sformatf("t%0d_latency", t), lat, tbl[t].e_lat);
    end

    // Concurrency: hold times 60/26/16/3 released together.
    i_sw = 4'b1110;
    repeat (34) step();
    i_sw = 4'b1100;
    repeat (10) step();
    i_sw = 4'b1000;
    repeat (13) step();
    i_sw = 4'b0000;
    repeat (3) step();
    i_sw = 4'b1111;
    repeat (4) step();
    check("conc_short", int'(o_short), 4'b0100);
    check("conc_long", int'(o_long), 4'b0010);
    check("conc_hold", int'(o_hold), 0);
    repeat (10) step();

    // Reset in the middle of an accepted press, button kept down.
    i_sw[2] = 1'b0;
    repeat (20) step();
    check("midreset_pre", int'(o_pressed[2]), 1);
    #1 i_rst_n = 1'b0;
    model_reset();
    #1 check("midreset_clear", int'({o_pressed, o_short, o_long, o_hold, o_repeat}), 0);
    repeat (2) step();
    i_rst_n = 1'b1;
    measure_accept(2, "midreset_accept");
    i_sw[2] = 1'b1;
    repeat (20) step();

    // Randomised press/bounce traffic on all channels.
    for (int c = 0; c < int'(CH); c++) rem[c] = 0;
    for (int n = 0; n < 4000; n++) begin
      for (int c = 0; c < int'(CH); c++) begin
        if (rem[c] == 0) begin
          i_sw[c] = ~i_sw[c];
          if ($urandom_range(0, 3) == 0) rem[c] = int'($urandom_range(1, 4));
          else if (!i_sw[c])             rem[c] = int'($urandom_range(5, 80));
          else                           rem[c] = int'($urandom_range(5, 30));
        end else begin
          rem[c]--;
        end
      end
      step();
    end
    i_sw = '1;
    repeat (10) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
